// File: rtl/y86_dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// y86_mem_pkg
// Shared definitions for the Y86 data-memory controller:
//   - icode constants for the six memory-touching instructions
//   - FSM state type (IDLE -> WAIT -> RESP)
//   - helpers that classify an icode as a memory write or a memory read,
//     and tell which operand carries the address
// ---------------------------------------------------------------------------
package y86_mem_pkg;

   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic is_mem_wr(input logic [3:0] icode);
      return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
   endfunction

   function automatic logic is_mem_rd(input logic [3:0] icode);
      return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
   endfunction

   // ret/popq read the stack through valA; every other access addresses via valE.
   function automatic logic addr_from_vala(input logic [3:0] icode);
      return (icode == I_RET) || (icode == I_POPQ);
   endfunction

endpackage

// File: rtl/y86_dmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// y86_dmem_if
// Request/response bus between the execute stage (master) and the data
// memory controller (slave).
//   req_valid/req_ready, icode, valA, valE, valP      : request channel
//   resp_valid, valM, dmem_error, err_sticky, parity_err : response channel
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1; the slave samples icode/valA/valE/valP only on that
// edge. req_ready is 1 only while the slave is idle. The response channel
// has no back-pressure: resp_valid is a one-cycle strobe and the response
// fields keep their last value until the next strobe.
// ---------------------------------------------------------------------------
interface y86_dmem_if #(
   parameter int DATA_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        icode;
   logic [DATA_W-1:0] valA;
   logic [DATA_W-1:0] valE;
   logic [DATA_W-1:0] valP;
   logic              resp_valid;
   logic [DATA_W-1:0] valM;
   logic              dmem_error;
   logic              err_sticky;
   logic              parity_err;

   modport master (
      output req_valid, icode, valA, valE, valP,
      input  req_ready, resp_valid, valM, dmem_error, err_sticky, parity_err
   );

   modport slave (
      input  req_valid, icode, valA, valE, valP,
      output req_ready, resp_valid, valM, dmem_error, err_sticky, parity_err
   );
endinterface

// File: rtl/y86_dmem_ctrl_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, W bits x DEPTH words, one-cycle read latency.
//   clk_i    : clock, rising edge
//   we_i     : write enable (write of wdata_i to addr_i on this edge)
//   addr_i   : word index for both read and write
//   wdata_i  : write data
//   rdata_o  : registered read data of the word addressed on the previous edge
// The array has no reset; it powers up cleared (zero) and keeps its contents
// across controller resets. A read of the word being written returns the
// old contents (read-first).
// ---------------------------------------------------------------------------
module dmem_ram #(
   parameter int W     = 64,
   parameter int DEPTH = 8192,
   parameter int AW    = 13
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/y86_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// y86_dmem_ctrl
// Y86 data memory: serves mrmovq/rmmovq/call/ret/pushq/popq with a
// programmable number of wait states, alignment/bounds checking on every
// access and an optional per-word even-parity bit.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : y86_dmem_if slave (request/response handshake, see interface)
//   state_o  : current FSM state, for debug/observation
// Parameters: DATA_W (word width, multiple of 8), DEPTH (words),
//             RD_LAT (wait states between accept and response, 0..15).
// Build option: define DMEM_PARITY_EN to store and check a parity bit per
// word; otherwise parity_err is tied to 0.
// ---------------------------------------------------------------------------
module y86_dmem_ctrl
   import y86_mem_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8192,
   parameter int RD_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   y86_dmem_if.slave  bus,
   output state_e     state_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int OB    = $clog2(BYTES);
`ifdef DMEM_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif
   // Bounds limit is one bit wider than an address so that DEPTH*BYTES
   // itself is representable and the compare sees all address bits.
   localparam logic [DATA_W:0]   LIMIT      = (DATA_W+1)'(DEPTH) * (DATA_W+1)'(BYTES);
   localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(BYTES - 1);
   localparam logic [3:0]        CNT_INIT   = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic [AW-1:0]     addr_q;
   logic              rd_q;
   logic              err_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] valm_hold_q;
   logic              err_hold_q;
   logic              par_hold_q;
   logic              sticky_q;

   logic              accept;
   logic [DATA_W-1:0] req_addr;
   logic              req_is_mem;
   logic              req_err;
   logic [DATA_W-1:0] wr_data;
   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic [RAM_W-1:0]  ram_wdata;
   logic [RAM_W-1:0]  ram_rdata;
   logic [DATA_W-1:0] resp_valm;
   logic              resp_par;
   logic              resp_err;

   // ---------------- request decode (only meaningful on accept) -------------
   assign accept     = bus.req_valid && (state_q == IDLE);
   assign req_addr   = addr_from_vala(bus.icode) ? bus.valA : bus.valE;
   assign req_is_mem = is_mem_wr(bus.icode) || is_mem_rd(bus.icode);
   assign req_err    = req_is_mem &&
                       ((|(req_addr & ALIGN_MASK)) || ({1'b0, req_addr} >= LIMIT));
   assign wr_data    = (bus.icode == I_CALL) ? bus.valP : bus.valA;

   // Writes commit on the accept edge. The array read address follows the
   // live request while idle (covers RD_LAT==0) and the captured address
   // while waiting, so the last cycle before RESP always reads addr_q.
   assign ram_we   = accept && is_mem_wr(bus.icode) && !req_err;
   assign ram_addr = (state_q == IDLE) ? req_addr[OB +: AW] : addr_q;

`ifdef DMEM_PARITY_EN
   assign ram_wdata = {^wr_data, wr_data};
   // Stored word plus its parity bit must have an even number of ones.
   assign resp_par  = rd_q && (^ram_rdata);
`else
   assign ram_wdata = wr_data;
   assign resp_par  = 1'b0;
`endif

   // Raw data is returned even on a parity mismatch; only legal reads return data.
   assign resp_valm = rd_q ? ram_rdata[DATA_W-1:0] : '0;
   assign resp_err  = err_q || resp_par;

   dmem_ram #(
      .W     (RAM_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // ---------------- FSM, wait counter, response registers ------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= '0;
         rd_q         <= 1'b0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         valm_hold_q  <= '0;
         err_hold_q   <= 1'b0;
         par_hold_q   <= 1'b0;
         sticky_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q <= req_addr[OB +: AW];
                  rd_q   <= is_mem_rd(bus.icode) && !req_err;
                  err_q  <= req_err;
                  if (RD_LAT == 0) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               valm_hold_q  <= resp_valm;
               err_hold_q   <= resp_err;
               par_hold_q   <= resp_par;
               sticky_q     <= sticky_q || resp_err;
            end
            default: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // The RAM data lands in the RESP cycle itself, so the response fields show
   // the live result during the strobe and the held copy afterwards.
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.valM       = resp_valid_q ? resp_valm : valm_hold_q;
   assign bus.dmem_error = resp_valid_q ? resp_err  : err_hold_q;
   assign bus.parity_err = resp_valid_q ? resp_par  : par_hold_q;
   assign bus.err_sticky = sticky_q || (resp_valid_q && resp_err);
   assign state_o        = state_q;

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_y86_dmem_ctrl
// Drives two controllers in lock-step with the same request stream: one with
// RD_LAT=2 and one with RD_LAT=0. Each request waits until both are idle, so
// both see identical memory traffic. Responses are compared against a
// word-addressed reference memory (associative array) computed from the
// instruction semantics; expected read data goes through exp_q.
// ---------------------------------------------------------------------------
module tb_y86_dmem_ctrl;
   import y86_mem_pkg::*;

   localparam int DATA_W = 64;
   localparam int DEPTH  = 8192;
   localparam int LAT0   = 2;
   localparam int LAT1   = 0;
   localparam int POOL   = 40;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- DUTs ----------------
   logic        req_valid;
   logic [3:0]  req_icode;
   logic [63:0] req_a, req_e, req_p;
   state_e      dbg0, dbg1;

   y86_dmem_if #(.DATA_W(DATA_W)) bus0 ();
   y86_dmem_if #(.DATA_W(DATA_W)) bus1 ();

   assign bus0.req_valid = req_valid;
   assign bus0.icode     = req_icode;
   assign bus0.valA      = req_a;
   assign bus0.valE      = req_e;
   assign bus0.valP      = req_p;
   assign bus1.req_valid = req_valid;
   assign bus1.icode     = req_icode;
   assign bus1.valA      = req_a;
   assign bus1.valE      = req_e;
   assign bus1.valP      = req_p;

   y86_dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(LAT0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .state_o(dbg0));
   y86_dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(LAT1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .state_o(dbg1));

   // ---------------- scoreboard / reference model ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];
   logic        exp_err_q[$];
   logic [63:0] mem_m [int];
   bit          bad_m [int];
   logic        sticky_m;
   logic [63:0] last_v0;
   logic        last_e0, last_p0;

   typedef struct {
      logic [63:0] valm;
      logic        err;
      logic        par;
   } exp_t;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Instruction semantics at word level: address choice, error rule,
   // memory update and read value.
   function automatic exp_t model_step(input logic [3:0] ic, input logic [63:0] a,
                                       input logic [63:0] e, input logic [63:0] p);
      exp_t r;
      longint unsigned addr;
      int w;
      bit rd, wr;
      r.valm = 64'd0;
      r.err  = 1'b0;
      r.par  = 1'b0;
      rd = ic inside {4'h5, 4'h9, 4'hB};
      wr = ic inside {4'h4, 4'h8, 4'hA};
      if (!(rd || wr)) return r;
      addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
      if ((addr % 8) != 0 || addr >= 64'(DEPTH) * 8) begin
         r.err = 1'b1;
         return r;
      end
      w = int'(addr / 8);
      if (wr) begin
         mem_m[w] = (ic == 4'h8) ? p : a;
         bad_m[w] = 1'b0;
      end else begin
         r.valm = mem_m.exists(w) ? mem_m[w] : 64'd0;
         if (bad_m.exists(w) && bad_m[w]) begin
            r.par = 1'b1;
            r.err = 1'b1;
         end
      end
      return r;
   endfunction

   // ---------------- driver ----------------
   task automatic transact(input logic [3:0] ic, input logic [63:0] a,
                           input logic [63:0] e, input logic [63:0] p);
      exp_t x;
      int guard, lat0, lat1, hi1;
      bit got0, got1;
      logic [63:0] v0, v1, ev;
      logic er0, er1, pr0, pr1, ee;
      guard = 0;
      while (!(bus0.req_ready && bus1.req_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("ready_wait", 64'(bus0.req_ready && bus1.req_ready), 64'd1);
      x = model_step(ic, a, e, p);
      exp_q.push_back(x.valm);
      exp_err_q.push_back(x.err);
      sticky_m = sticky_m | x.err;
      req_icode = ic; req_a = a; req_e = e; req_p = p;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      // Junk on the request fields while busy must be ignored.
      req_icode = 4'($urandom); req_a = rand64(); req_e = rand64(); req_p = rand64();
      got0 = 0; got1 = 0; lat0 = 0; lat1 = 0; hi1 = 0;
      v0 = 0; v1 = 0; er0 = 0; er1 = 0; pr0 = 0; pr1 = 0;
      for (int c = 1; c <= 40 && !(got0 && got1); c++) begin
         if (c > 1) @(negedge clk);
         if (c == 1) check("busy_ready0", 64'(bus0.req_ready), 64'd0);
         if (bus0.resp_valid && !got0) begin
            got0 = 1; lat0 = c;
            v0 = bus0.valM; er0 = bus0.dmem_error; pr0 = bus0.parity_err;
         end
         if (bus1.resp_valid) begin
            hi1++;
            if (!got1) begin
               got1 = 1; lat1 = c;
               v1 = bus1.valM; er1 = bus1.dmem_error; pr1 = bus1.parity_err;
            end
         end
      end
      check("resp0_seen", 64'(got0), 64'd1);
      check("resp1_seen", 64'(got1), 64'd1);
      ev = exp_q.pop_front();
      ee = exp_err_q.pop_front();
      check("valM0", v0, ev);
      check("valM1", v1, ev);
      check("err0", 64'(er0), 64'(ee));
      check("err1", 64'(er1), 64'(ee));
      check("par0", 64'(pr0), 64'(x.par));
      check("par1", 64'(pr1), 64'(x.par));
      check("lat0", 64'(lat0), 64'(LAT0 + 1));
      check("lat1", 64'(lat1), 64'(LAT1 + 1));
      check("strobe1", 64'(hi1), 64'd1);
      @(negedge clk);
      check("strobe0", 64'(bus0.resp_valid), 64'd0);
      check("hold_valM0", bus0.valM, ev);
      check("hold_err0", 64'(bus0.dmem_error), 64'(ee));
      check("sticky0", 64'(bus0.err_sticky), 64'(sticky_m));
      check("sticky1", 64'(bus1.err_sticky), 64'(sticky_m));
      last_v0 = v0; last_e0 = er0; last_p0 = pr0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_rv0"},  64'(bus0.resp_valid), 64'd0);
      check({tag, "_rdy0"}, 64'(bus0.req_ready),  64'd1);
      check({tag, "_vm0"},  bus0.valM,            64'd0);
      check({tag, "_er0"},  64'(bus0.dmem_error), 64'd0);
      check({tag, "_st0"},  64'(bus0.err_sticky), 64'd0);
      check({tag, "_pe0"},  64'(bus0.parity_err), 64'd0);
      check({tag, "_fsm0"}, 64'(dbg0),            64'(IDLE));
      check({tag, "_rv1"},  64'(bus1.resp_valid), 64'd0);
      check({tag, "_rdy1"}, 64'(bus1.req_ready),  64'd1);
      check({tag, "_vm1"},  bus1.valM,            64'd0);
      check({tag, "_st1"},  64'(bus1.err_sticky), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   function automatic logic [63:0] gen_addr();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return 64'($urandom_range(0, POOL - 1) * 8 + $urandom_range(1, 7));
      if (r == 1) return 64'(DEPTH) * 8 + 64'($urandom_range(0, 100) * 8);
      if (r == 2) return rand64() | 64'h8000_0000_0000_0000;
      return 64'($urandom_range(0, POOL - 1) * 8);
   endfunction

   initial begin
      logic [3:0] ic_tab [10];
      logic [3:0] ic;
      int cnt;
      ic_tab = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h5, 4'h0, 4'h6, 4'hF};
      rst_n = 1'b0; sticky_m = 1'b0;
      req_valid = 1'b0; req_icode = 4'h0; req_a = 0; req_e = 0; req_p = 0;
      last_v0 = 0; last_e0 = 0; last_p0 = 0;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Known contents for the address pool used by the random phase.
      for (int i = 0; i < POOL; i++) transact(I_RMMOVQ, rand64(), 64'(i * 8), rand64());

      // Store/load round trip.
      transact(I_RMMOVQ, 64'hDEAD_BEEF, 64'h40, 64'h0);
      transact(I_MRMOVQ, 64'h0, 64'h40, 64'h0);
      check("t1_valM", last_v0, 64'hDEAD_BEEF);
      check("t1_err", 64'(last_e0), 64'd0);

      // call/ret and pushq/popq through the stack operands.
      transact(I_CALL, 64'h5555, 64'h100, 64'h2A);
      transact(I_RET, 64'h100, 64'h0, 64'h0);
      check("t2_ret", last_v0, 64'h2A);
      transact(I_PUSHQ, 64'h7, 64'h108, 64'h0);
      transact(I_POPQ, 64'h108, 64'h0, 64'h0);
      check("t2_pop", last_v0, 64'h7);

      // Non-memory icodes leave memory alone.
      transact(4'h0, rand64(), 64'h40, rand64());
      transact(4'h6, rand64(), 64'h40, rand64());
      transact(I_MRMOVQ, 64'h0, 64'h40, 64'h0);
      check("t4_unchanged", last_v0, 64'hDEAD_BEEF);

      // Misaligned and out-of-range accesses.
      transact(I_MRMOVQ, 64'h0, 64'h43, 64'h0);
      check("t3_mis_err", 64'(last_e0), 64'd1);
      check("t3_mis_valM", last_v0, 64'd0);
      transact(I_RMMOVQ, 64'h1234_5678, 64'(DEPTH) * 8, 64'h0);
      check("t3_oob_err", 64'(last_e0), 64'd1);
      transact(I_RMMOVQ, 64'h9999, 64'h8000_0000_0000_0040, 64'h0);
      transact(I_MRMOVQ, 64'h0, 64'h0, 64'h0);
      transact(I_MRMOVQ, 64'h0, 64'h40, 64'h0);
      check("t3_no_wrap", last_v0, 64'hDEAD_BEEF);
      check("t3_sticky", 64'(bus0.err_sticky), 64'd1);

`ifdef DMEM_PARITY_EN
      transact(I_RMMOVQ, 64'h0123_4567_89AB_CDEF, 64'h320, 64'h0);
      dut0.u_ram.mem[100][3] = ~dut0.u_ram.mem[100][3];
      dut1.u_ram.mem[100][3] = ~dut1.u_ram.mem[100][3];
      mem_m[100] = mem_m[100] ^ 64'h8;
      bad_m[100] = 1'b1;
      transact(I_MRMOVQ, 64'h0, 64'h320, 64'h0);
      check("t6_par_flag", 64'(last_p0), 64'd1);
      check("t6_par_err", 64'(last_e0), 64'd1);
      check("t6_raw_data", last_v0, 64'h0123_4567_89AB_CDE7);
`else
      transact(I_RMMOVQ, 64'h0123_4567_89AB_CDEF, 64'h320, 64'h0);
      transact(I_MRMOVQ, 64'h0, 64'h320, 64'h0);
      check("t6_par_off", 64'(last_p0), 64'd0);
`endif

      // Reset while a load is waiting: request dropped, outputs cleared.
      req_icode = I_MRMOVQ; req_e = 64'h40; req_a = 0; req_p = 0;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("t5_in_wait", 64'(dbg0), 64'(WAIT));
      #2 rst_n = 1'b0;
      #1 check_cleared("t5_rst");
      sticky_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus0.resp_valid || bus1.resp_valid) cnt++;
      end
      check("t5_no_resp", 64'(cnt), 64'd0);
      transact(I_MRMOVQ, 64'h0, 64'h40, 64'h0);
      check("t5_after", last_v0, 64'hDEAD_BEEF);

      // Randomized traffic over the pool, with occasional bad addresses.
      for (int n = 0; n < 80; n++) begin
         logic [63:0] a;
         ic = ic_tab[$urandom_range(0, 9)];
         a = (ic == I_RET || ic == I_POPQ) ? gen_addr() : rand64();
         transact(ic, a, gen_addr(), rand64());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
